// File: rtl/instr_register_reader.sv
`default_nettype none
// ============================================================================
//  Module   : instr_register_reader
//  Purpose  : Read-side sequencer for the instruction register. Walks
//             read_pointer from start_addr over `count` entries, captures each
//             instruction_word {opcode, operand_a, operand_b}, evaluates the
//             opcode and presents one result per entry on a valid/ready stream.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W  read_pointer width, register depth = 2**ADDR_W
//    OPC_W   opcode field width
//    OP_W    signed operand width, results are 2*OP_W wide
//    RD_LAT  cycles from a read_pointer update to a valid instruction_word
//            (legal range 0..3)
//  Ports
//    clk, reset          rising-edge clock, synchronous active-high reset
//    start               one-cycle sweep request, only honoured while idle
//    start_addr, count   first entry and number of entries (0..2**ADDR_W)
//    read_pointer        address into the instruction register
//    instruction_word    {opcode, operand_a, operand_b}, opcode in the MSBs
//    res_valid/res_ready result handshake
//    res_addr/res_opcode entry address and opcode of the presented result
//    res_value, res_err  sign-extended result, error flag
//    busy, done          sweep in progress, one-cycle completion pulse
//  Build option
//    INSTR_READER_STATS_EN  adds saturating stat_results / stat_errors
// ============================================================================
module instr_register_reader #(
  parameter int ADDR_W = 5,
  parameter int OPC_W  = 4,
  parameter int OP_W   = 32,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [ADDR_W:0]          count,
  output logic [ADDR_W-1:0]        read_pointer,
  input  logic [OPC_W+2*OP_W-1:0]  instruction_word,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ADDR_W-1:0]        res_addr,
  output logic [OPC_W-1:0]         res_opcode,
  output logic signed [2*OP_W-1:0] res_value,
  output logic                     res_err,
  output logic                     busy,
  output logic                     done
`ifdef INSTR_READER_STATS_EN
  ,
  output logic [15:0]              stat_results,
  output logic [15:0]              stat_errors
`endif
);

  localparam int c_iw_w  = OPC_W + 2*OP_W;
  localparam int c_res_w = 2*OP_W;

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_issue   = 3'd1;
  localparam logic [2:0] c_st_wait    = 3'd2;
  localparam logic [2:0] c_st_capture = 3'd3;
  localparam logic [2:0] c_st_exec    = 3'd4;
  localparam logic [2:0] c_st_hold    = 3'd5;

  localparam logic [OPC_W-1:0] c_opc_zero  = OPC_W'(0);
  localparam logic [OPC_W-1:0] c_opc_passa = OPC_W'(1);
  localparam logic [OPC_W-1:0] c_opc_passb = OPC_W'(2);
  localparam logic [OPC_W-1:0] c_opc_add   = OPC_W'(3);
  localparam logic [OPC_W-1:0] c_opc_sub   = OPC_W'(4);
  localparam logic [OPC_W-1:0] c_opc_mult  = OPC_W'(5);
  localparam logic [OPC_W-1:0] c_opc_div   = OPC_W'(6);
  localparam logic [OPC_W-1:0] c_opc_mod   = OPC_W'(7);

  // The WAIT counter is loaded with RD_LAT-1 and WAIT exits when it reads 0,
  // so WAIT lasts exactly RD_LAT cycles.
  localparam logic [1:0]        c_wait_init = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;
  localparam logic [ADDR_W:0]   c_one_entry = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_ptr_step  = ADDR_W'(1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [2:0]               state_q,     state_d;
  logic [ADDR_W-1:0]        rp_q,        rp_d;
  logic [ADDR_W:0]          remaining_q, remaining_d;
  logic [1:0]               wait_cnt_q,  wait_cnt_d;
  logic [OPC_W-1:0]         opc_q,       opc_d;
  logic signed [OP_W-1:0]   opa_q,       opa_d;
  logic signed [OP_W-1:0]   opb_q,       opb_d;
  logic                     res_valid_q, res_valid_d;
  logic [ADDR_W-1:0]        res_addr_q,  res_addr_d;
  logic signed [c_res_w-1:0] res_value_q, res_value_d;
  logic                     res_err_q,   res_err_d;
  logic                     busy_q,      busy_d;
  logic                     done_q,      done_d;

  // --------------------------------------------------------------------------
  // Execute datapath: operands are widened to 2*OP_W before any arithmetic so
  // sums, differences and the product never overflow and the one signed
  // division overflow case (most-negative / -1) yields the exact quotient.
  // --------------------------------------------------------------------------
  logic signed [c_res_w-1:0] w_a_ext;
  logic signed [c_res_w-1:0] w_b_ext;
  logic signed [c_res_w-1:0] w_b_div;
  logic signed [c_res_w-1:0] w_sum;
  logic signed [c_res_w-1:0] w_diff;
  logic signed [c_res_w-1:0] w_prod;
  logic signed [c_res_w-1:0] w_quot;
  logic signed [c_res_w-1:0] w_rem;
  logic signed [c_res_w-1:0] w_exec_value;
  logic                      w_b_zero;
  logic                      w_exec_err;
  logic                      w_handshake;

  assign w_a_ext  = {{OP_W{opa_q[OP_W-1]}}, opa_q};
  assign w_b_ext  = {{OP_W{opb_q[OP_W-1]}}, opb_q};
  assign w_b_zero = (opb_q == '0);
  // The divider never sees a zero divisor; the zero case is reported as an
  // error below and its quotient/remainder are discarded.
  assign w_b_div  = w_b_zero ? c_res_w'(1) : w_b_ext;
  assign w_sum    = w_a_ext + w_b_ext;
  assign w_diff   = w_a_ext - w_b_ext;
  assign w_prod   = w_a_ext * w_b_ext;
  assign w_quot   = w_a_ext / w_b_div;   // truncates toward zero
  assign w_rem    = w_a_ext % w_b_div;   // sign follows the dividend

  always_comb begin
    w_exec_value = '0;
    w_exec_err   = 1'b0;
    case (opc_q)
      c_opc_zero:  w_exec_value = '0;
      c_opc_passa: w_exec_value = w_a_ext;
      c_opc_passb: w_exec_value = w_b_ext;
      c_opc_add:   w_exec_value = w_sum;
      c_opc_sub:   w_exec_value = w_diff;
      c_opc_mult:  w_exec_value = w_prod;
      c_opc_div: begin
        if (w_b_zero) w_exec_err   = 1'b1;
        else          w_exec_value = w_quot;
      end
      c_opc_mod: begin
        if (w_b_zero) w_exec_err   = 1'b1;
        else          w_exec_value = w_rem;
      end
      default:     w_exec_err = 1'b1;
    endcase
  end

  // res_valid is only ever set in HOLD, so this is the accepted-result event.
  assign w_handshake = res_valid_q && res_ready;

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rp_d        = rp_q;
    remaining_d = remaining_q;
    wait_cnt_d  = wait_cnt_q;
    opc_d       = opc_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_valid_d = res_valid_q;
    res_addr_d  = res_addr_q;
    res_value_d = res_value_q;
    res_err_d   = res_err_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      c_st_idle: begin
        if (start) begin
          if (count != '0) begin
            rp_d        = start_addr;
            remaining_d = count;
            busy_d      = 1'b1;
            state_d     = c_st_issue;
          end else begin
            // Empty sweep: report completion without touching the register.
            done_d = 1'b1;
          end
        end
      end

      c_st_issue: begin
        if (RD_LAT == 0) begin
          state_d = c_st_capture;
        end else begin
          wait_cnt_d = c_wait_init;
          state_d    = c_st_wait;
        end
      end

      c_st_wait: begin
        if (wait_cnt_q == 2'd0) state_d    = c_st_capture;
        else                    wait_cnt_d = wait_cnt_q - 2'd1;
      end

      c_st_capture: begin
        opc_d      = instruction_word[c_iw_w-1 -: OPC_W];
        opa_d      = instruction_word[2*OP_W-1 -: OP_W];
        opb_d      = instruction_word[OP_W-1:0];
        res_addr_d = rp_q;
        state_d    = c_st_exec;
      end

      c_st_exec: begin
        res_value_d = w_exec_value;
        res_err_d   = w_exec_err;
        res_valid_d = 1'b1;
        state_d     = c_st_hold;
      end

      c_st_hold: begin
        if (w_handshake) begin
          res_valid_d = 1'b0;
          remaining_d = remaining_q - c_one_entry;
          if (remaining_q == c_one_entry) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = c_st_idle;
          end else begin
            rp_d    = rp_q + c_ptr_step;   // wraps modulo the register depth
            state_d = c_st_issue;
          end
        end
      end

      default: begin
        state_d     = c_st_idle;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= c_st_idle;
      rp_q        <= '0;
      remaining_q <= '0;
      wait_cnt_q  <= '0;
      opc_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
      res_value_q <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rp_q        <= rp_d;
      remaining_q <= remaining_d;
      wait_cnt_q  <= wait_cnt_d;
      opc_q       <= opc_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      res_valid_q <= res_valid_d;
      res_addr_q  <= res_addr_d;
      res_value_q <= res_value_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign read_pointer = rp_q;
  assign res_valid    = res_valid_q;
  assign res_addr     = res_addr_q;
  // The captured opcode register only changes in CAPTURE, while res_valid is
  // low, so it doubles as the stable res_opcode output.
  assign res_opcode   = opc_q;
  assign res_value    = res_value_q;
  assign res_err      = res_err_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef INSTR_READER_STATS_EN
  // --------------------------------------------------------------------------
  // Result statistics: saturating, cleared only by reset.
  // --------------------------------------------------------------------------
  logic [15:0] stat_results_q, stat_results_d;
  logic [15:0] stat_errors_q,  stat_errors_d;

  always_comb begin
    stat_results_d = stat_results_q;
    stat_errors_d  = stat_errors_q;
    if (w_handshake) begin
      if (stat_results_q != 16'hFFFF) stat_results_d = stat_results_q + 16'd1;
      if (res_err_q && (stat_errors_q != 16'hFFFF)) stat_errors_d = stat_errors_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_results_q <= '0;
      stat_errors_q  <= '0;
    end else begin
      stat_results_q <= stat_results_d;
      stat_errors_q  <= stat_errors_d;
    end
  end

  assign stat_results = stat_results_q;
  assign stat_errors  = stat_errors_q;
`endif

endmodule
`default_nettype wire
